// File: rtl/butterfly_pipe.sv
// Radix-2 complex butterfly A +/- W*B with optional conj(W) and 1/2 scaling.
// Three registered stages (operands, products, rounded/saturated results) with a global stall.
module butterfly_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic             inv,
  input  logic             scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] apwb,
  output logic [WIDTH-1:0] anwb,
  output logic             sat,
  output logic             sat_sticky,
  input  logic             sat_clr
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H;
  localparam int SW = H + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(H-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(H-1){1'b0}}};
  localparam logic signed [PW:0]   RND  = {{(H+2){1'b0}}, 1'b1, {(H-2){1'b0}}};

  // Negating the most negative Q1 value has no representation; clamp it.
  function automatic logic signed [H-1:0] neg_sat(input logic signed [H-1:0] x);
    logic signed [H-1:0] r;
    if (x == {1'b1, {(H-1){1'b0}}}) r = {1'b0, {(H-1){1'b1}}};
    else                            r = -x;
    return r;
  endfunction

  function automatic logic signed [SW-1:0] round_wb(input logic signed [PW:0] x);
    logic signed [PW:0] t;
    t = x + RND;
    return t[PW:H-1];
  endfunction

  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] x);
    return {x[SW-1], x[SW-1:1]};
  endfunction

  // Returns {saturated_flag, clamped component}.
  function automatic logic [H:0] sat_comp(input logic signed [SW-1:0] x);
    logic [H:0] r;
    if (x > SMAX)      r = {1'b1, SMAX[H-1:0]};
    else if (x < SMIN) r = {1'b1, SMIN[H-1:0]};
    else               r = {1'b0, x[H-1:0]};
    return r;
  endfunction

  logic stall;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  assign out_valid = vld_p3_q;
  assign stall     = vld_p3_q && !out_ready;
  assign in_ready  = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (!stall) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- stage 1: operands, conjugated twiddle, scale bit
  logic signed [H-1:0] wim_d;
  logic [WIDTH-1:0]    a_p1_q;
  logic signed [H-1:0] bre_p1_q, bim_p1_q, wre_p1_q, wim_p1_q;
  logic                scale_p1_q;

  assign wim_d = inv ? neg_sat(w[H-1:0]) : w[H-1:0];

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_p1_q     <= a;
      bre_p1_q   <= b[WIDTH-1:H];
      bim_p1_q   <= b[H-1:0];
      wre_p1_q   <= w[WIDTH-1:H];
      wim_p1_q   <= wim_d;
      scale_p1_q <= scale;
    end
  end

  // ---- stage 2: full-precision partial products
  logic signed [PW-1:0] wre_x, wim_x, bre_x, bim_x;
  logic signed [PW-1:0] prr_p2_q, pii_p2_q, pir_p2_q, pri_p2_q;
  logic [WIDTH-1:0]     a_p2_q;
  logic                 scale_p2_q;

  assign wre_x = {{H{wre_p1_q[H-1]}}, wre_p1_q};
  assign wim_x = {{H{wim_p1_q[H-1]}}, wim_p1_q};
  assign bre_x = {{H{bre_p1_q[H-1]}}, bre_p1_q};
  assign bim_x = {{H{bim_p1_q[H-1]}}, bim_p1_q};

  always_ff @(posedge clk) begin
    if (!stall) begin
      prr_p2_q   <= wre_x * bre_x;
      pii_p2_q   <= wim_x * bim_x;
      pir_p2_q   <= wim_x * bre_x;
      pri_p2_q   <= wre_x * bim_x;
      a_p2_q     <= a_p1_q;
      scale_p2_q <= scale_p1_q;
    end
  end

  // ---- stage 3: combine, round, add/subtract, scale, saturate
  logic signed [PW:0]   wbr, wbi;
  logic signed [SW-1:0] wbr_r, wbi_r, are, aim;
  logic signed [SW-1:0] spr, spi, snr, sni;
  logic [H:0]           cpr, cpi, cnr, cni;
  logic [WIDTH-1:0]     apwb_d, anwb_d;
  logic                 sat_d;

  always_comb begin
    wbr   = {prr_p2_q[PW-1], prr_p2_q} - {pii_p2_q[PW-1], pii_p2_q};
    wbi   = {pir_p2_q[PW-1], pir_p2_q} + {pri_p2_q[PW-1], pri_p2_q};
    wbr_r = round_wb(wbr);
    wbi_r = round_wb(wbi);
    are   = {{2{a_p2_q[WIDTH-1]}}, a_p2_q[WIDTH-1:H]};
    aim   = {{2{a_p2_q[H-1]}}, a_p2_q[H-1:0]};
    spr   = are + wbr_r;
    spi   = aim + wbi_r;
    snr   = are - wbr_r;
    sni   = aim - wbi_r;
    if (scale_p2_q) begin
      spr = half(spr);
      spi = half(spi);
      snr = half(snr);
      sni = half(sni);
    end
    cpr    = sat_comp(spr);
    cpi    = sat_comp(spi);
    cnr    = sat_comp(snr);
    cni    = sat_comp(sni);
    apwb_d = {cpr[H-1:0], cpi[H-1:0]};
    anwb_d = {cnr[H-1:0], cni[H-1:0]};
    sat_d  = cpr[H] | cpi[H] | cnr[H] | cni[H];
  end

  logic [WIDTH-1:0] apwb_p3_q, anwb_p3_q;
  logic             sat_p3_q, sat_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apwb_p3_q <= '0;
      anwb_p3_q <= '0;
      sat_p3_q  <= 1'b0;
    end else if (!stall) begin
      apwb_p3_q <= apwb_d;
      anwb_p3_q <= anwb_d;
      sat_p3_q  <= sat_d;
    end
  end

  // A saturating transfer beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  sat_sticky_q <= 1'b0;
    else if (vld_p3_q && out_ready && sat_p3_q)  sat_sticky_q <= 1'b1;
    else if (sat_clr)                            sat_sticky_q <= 1'b0;
  end

  assign apwb       = apwb_p3_q;
  assign anwb       = anwb_p3_q;
  assign sat        = sat_p3_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 WIDTH, 32, packed complex word width; even, >=8; H = WIDTH/2 is the per-component width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-004 in_valid  in  1  input operand triple valid.
REQ-005 in_ready  out  1  block accepts the triple this cycle.
REQ-006 a  in  WIDTH  operand A, packed {re[WIDTH-1:H], im[H-1:0]}, signed two's complement.
REQ-007 b  in  WIDTH  operand B, same packing.
REQ-008 w  in  WIDTH  twiddle W, same packing, each component Q1.(H-1).
REQ-009 inv  in  1  1 = use conj(W) (inverse transform), sampled with the triple.
REQ-010 scale  in  1  1 = halve both outputs (per-stage 1/2 scaling), sampled with the triple.
REQ-011 out_valid  out  1  result pair valid.
REQ-012 out_ready  in  1  downstream accepts the result pair.
REQ-013 apwb  out  WIDTH  A + W*B, packed as a.
REQ-014 anwb  out  WIDTH  A - W*B, packed as a.
REQ-015 sat  out  1  at least one component of this result pair saturated; qualified by out_valid.
REQ-016 sat_sticky  out  1  OR of sat over all transfers since reset or clear.
REQ-017 sat_clr  in  1  synchronous clear of sat_sticky.

Function
REQ-018 Three-stage pipeline: S1 registers operands and mode bits; S2 registers the four full-precision H x H products; S3 registers the rounded, summed, saturated results.
REQ-019 Latency exactly 3 cycles from an accepted triple to out_valid with its result, absent stall.
REQ-020 Accept condition: in_valid && in_ready; output transfer condition: out_valid && out_ready.
REQ-021 stall = out_valid && !out_ready; in_ready = !stall; while stalled, every pipeline register, including valid bits, holds.
REQ-022 Without stall, one triple is accepted per cycle (full throughput); bubbles propagate as cleared valid bits.
REQ-023 inv=1: W_im is replaced by -W_im; -(-2^(H-1)) saturates to 2^(H-1)-1.
REQ-024 WB_re = W_re*B_re - W_im*B_im; WB_im = W_im*B_re + W_re*B_im; each computed at 2H+1 bits, no overflow.
REQ-025 Each WB component is scaled by 2^-(H-1) with round-half-up: add 2^(H-2), then arithmetic shift right by H-1; result kept at H+2 bits.
REQ-026 Sums/differences A±WB are formed at H+2 bits, no intermediate wrap.
REQ-027 scale=1: each sum is arithmetically shifted right by 1 (floor) before saturation.
REQ-028 Each component is saturated to [-2^(H-1), 2^(H-1)-1]; sat = OR of the four component saturation events for that pair.
REQ-029 sat_sticky sets on a transfer with sat=1; if sat_clr and such a transfer occur in the same cycle, set wins.
REQ-030 apwb, anwb and sat are stable and unchanged while out_valid && !out_ready.

Reset
REQ-031 While rst_n=0: all valid bits 0, out_valid=0, in_ready=1, apwb=anwb=0, sat=0, sat_sticky=0.
REQ-032 Reset asserted mid-operation discards all in-flight triples; no result emerges for them after release.
REQ-033 Data registers need no reset other than the outputs listed in REQ-031.

Verification (WIDTH=32, values re,im decimal)
REQ-034 Basic: A=(100,0), B=(200,0), W=(16384,0), inv=0, scale=0 -> 3 cycles later apwb=(200,0), anwb=(0,0), sat=0.
REQ-035 Scale: same stimulus with scale=1 -> apwb=(100,0), anwb=(0,0).
REQ-036 Saturation: A=(28672,0), B=(28672,0), W=(32767,0) -> apwb=(32767,0), anwb=(1,0), sat=1, sat_sticky=1 until sat_clr.
REQ-037 Inverse: A=(0,0), B=(100,0), W=(0,16384): inv=0 -> apwb=(0,50), anwb=(0,-50); inv=1 -> apwb=(0,-50), anwb=(0,50).
REQ-038 Backpressure: stream 8 random triples while out_ready toggles pseudo-randomly -> all 8 results delivered in order, none lost or duplicated, outputs stable during stall, matching a reference model.
REQ-039 Reset mid-stream: assert rst_n=0 with 2 triples in flight -> out_valid=0 immediately; after release no stale results, next accepted triple emerges after exactly 3 cycles.
